load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: issue handshake, memory request with timeout, load writeback.
// Optional store posting (one pending op behind a store) is enabled by defining LSU_STORE_POST_EN.
module load_store_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int TMO    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [3:0]        iss_op,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [DATA_W-1:0] iss_wdata,
    input  logic [REG_W-1:0]  iss_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err_op,
    output logic              err_tmo
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0100;

    localparam int CNT_W = $clog2(TMO + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              err_op_q, err_op_d;
    logic              err_tmo_q, err_tmo_d;
    // Keeps iss_ready low for the cycle that follows a reset edge.
    logic              rst_hold_q;

    logic              accept;
    logic              ready_state;
    logic              tmo_hit;
    logic              nxt_valid;
    logic [3:0]        nxt_op;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_wdata;
    logic [REG_W-1:0]  nxt_rd;

`ifdef LSU_STORE_POST_EN
    logic              pend_valid_q, pend_valid_d;
    logic [3:0]        pend_op_q, pend_op_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
    logic [REG_W-1:0]  pend_rd_q, pend_rd_d;

    assign ready_state = (state_q == IDLE) ||
                         (state_q == REQ && op_q == OP_STORE && !pend_valid_q);
`else
    assign ready_state = (state_q == IDLE);
`endif

    assign iss_ready = ready_state && !rst_hold_q;
    assign accept    = iss_valid && iss_ready;
    assign tmo_hit   = (cnt_q == CNT_W'(TMO - 1));

    assign mem_req   = (state_q == REQ);
    assign mem_we    = (state_q == REQ) && (op_q == OP_STORE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = (state_q == WB);
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign err_op    = err_op_q;
    assign err_tmo   = err_tmo_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        err_op_d  = 1'b0;
        err_tmo_d = 1'b0;
        nxt_valid = 1'b0;
        nxt_op    = iss_op;
        nxt_addr  = iss_addr;
        nxt_wdata = iss_wdata;
        nxt_rd    = iss_rd;
`ifdef LSU_STORE_POST_EN
        pend_valid_d = pend_valid_q;
        pend_op_d    = pend_op_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        pend_rd_d    = pend_rd_q;
`endif
        case (state_q)
            IDLE: nxt_valid = accept;
            REQ: begin
                if (mem_ack) begin
                    if (op_q == OP_LOAD) begin
                        state_d   = WB;
                        wb_data_d = mem_rdata;
                        wb_rd_d   = rd_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo_hit) begin
                    state_d   = IDLE;
                    err_tmo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`ifdef LSU_STORE_POST_EN
                // A store finishing (ack or abort) launches the queued op with no idle gap.
                if (op_q == OP_STORE && (mem_ack || tmo_hit)) begin
                    if (pend_valid_q) begin
                        nxt_valid    = 1'b1;
                        nxt_op       = pend_op_q;
                        nxt_addr     = pend_addr_q;
                        nxt_wdata    = pend_wdata_q;
                        nxt_rd       = pend_rd_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        nxt_valid = accept;
                    end
                end else if (accept) begin
                    pend_valid_d = 1'b1;
                    pend_op_d    = iss_op;
                    pend_addr_d  = iss_addr;
                    pend_wdata_d = iss_wdata;
                    pend_rd_d    = iss_rd;
                end
`endif
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (nxt_valid) begin
            if (nxt_op == OP_LOAD || nxt_op == OP_STORE) begin
                state_d = REQ;
                cnt_d   = '0;
                op_d    = nxt_op;
                addr_d  = nxt_addr;
                wdata_d = nxt_wdata;
                rd_d    = nxt_rd;
            end else begin
                err_op_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            err_op_q   <= 1'b0;
            err_tmo_q  <= 1'b0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_op_q   <= err_op_d;
            err_tmo_q  <= err_tmo_d;
            rst_hold_q <= 1'b0;
        end
    end

`ifdef LSU_STORE_POST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_op_q    <= '0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            pend_rd_q    <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            pend_rd_q    <= pend_rd_d;
        end
    end
`endif

endmodule
